// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: state encoding,
// master indices and the default watchdog limit.
package wb_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      GNT_INST  = 2'b01,
      GNT_DATA  = 2'b10,
      ERR_PULSE = 2'b11
   } arb_state_e;

   localparam logic MASTER_INST = 1'b0;
   localparam logic MASTER_DATA = 1'b1;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'd1024;

   // Grant state that serves the given master index.
   function automatic arb_state_e grant_state(input logic master);
      return (master == MASTER_INST) ? GNT_INST : GNT_DATA;
   endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Saturating per-transaction cycle counter; expired_o is registered and goes
// high once the count has reached TIMEOUT_CYCLES-1.
module wb_watchdog
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int unsigned TIMEOUT_WIDTH  = 32'd16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic [TIMEOUT_WIDTH-1:0] LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 32'd1);
   localparam logic [TIMEOUT_WIDTH-1:0] ONE   = TIMEOUT_WIDTH'(32'd1);

   logic [TIMEOUT_WIDTH-1:0] count_q, count_d;
   logic                     expired_q, expired_d;

   // Next-state: clear dominates, counting stops at all-ones instead of wrapping.
   always_comb begin
      count_d   = count_q;
      expired_d = expired_q;
      if (clear_i) begin
         count_d   = '0;
         expired_d = 1'b0;
      end else if (enable_i) begin
         count_d   = (&count_q) ? count_q : (count_q + ONE);
         expired_d = (count_d >= LIMIT);
      end else begin
         count_d   = count_q;
         expired_d = expired_q;
      end
   end

   // Counter and expiry flag registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q   <= '0;
         expired_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         expired_q <= expired_d;
      end
   end

   assign expired_o = expired_q;

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter merging the fetch and load/store Wishbone masters onto
// the memory controller's single CPU port, with a per-grant ACK watchdog.
module wishbone_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int unsigned TIMEOUT_WIDTH  = 32'd16
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        inst_CYC_I,
   input  logic        inst_STB_I,
   input  logic [31:0] inst_ADR_I,
   output logic [31:0] inst_DAT_O,
   output logic        inst_ACK_O,
   output logic        inst_ERR_O,
   input  logic        data_CYC_I,
   input  logic        data_STB_I,
   input  logic        data_WE_I,
   input  logic [3:0]  data_SEL_I,
   input  logic [31:0] data_ADR_I,
   input  logic [31:0] data_DAT_I,
   output logic [31:0] data_DAT_O,
   output logic        data_ACK_O,
   output logic        data_ERR_O,
   output logic        mem_CYC_O,
   output logic        mem_STB_O,
   output logic        mem_WE_O,
   output logic [3:0]  mem_SEL_O,
   output logic [31:0] mem_ADR_O,
   output logic [31:0] mem_DAT_O,
   input  logic [31:0] mem_DAT_I,
   input  logic        mem_ACK_I
);

   arb_state_e state_q;
   logic       last_grant_q;
   logic       inst_req_s, data_req_s;
   logic       wd_clear_s, wd_enable_s, wd_expired_s;

   assign inst_req_s  = inst_CYC_I & inst_STB_I;
   assign data_req_s  = data_CYC_I & data_STB_I;
   assign wd_clear_s  = (state_q != GNT_INST) && (state_q != GNT_DATA);
   assign wd_enable_s = ~wd_clear_s & ~mem_ACK_I;

   wb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
   ) u_watchdog (
      .clk_i     (CLK_I),
      .rst_ni    (RST_I),
      .clear_i   (wd_clear_s),
      .enable_i  (wd_enable_s),
      .expired_o (wd_expired_s)
   );

   // Arbitration FSM. ACK beats both abort and timeout so a late ACK on the
   // expiry cycle still completes normally; every exit passes through IDLE.
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state_q      <= IDLE;
         last_grant_q <= MASTER_DATA;
      end else begin
         case (state_q)
            IDLE: begin
               if (inst_req_s && (!data_req_s || (last_grant_q == MASTER_DATA))) begin
                  state_q <= grant_state(MASTER_INST);
               end else if (data_req_s) begin
                  state_q <= grant_state(MASTER_DATA);
               end else begin
                  state_q <= IDLE;
               end
            end
            GNT_INST: begin
               if (mem_ACK_I || !inst_CYC_I) begin
                  state_q      <= IDLE;
                  last_grant_q <= MASTER_INST;
               end else if (wd_expired_s) begin
                  state_q      <= ERR_PULSE;
                  last_grant_q <= MASTER_INST;
               end else begin
                  state_q <= GNT_INST;
               end
            end
            GNT_DATA: begin
               if (mem_ACK_I || !data_CYC_I) begin
                  state_q      <= IDLE;
                  last_grant_q <= MASTER_DATA;
               end else if (wd_expired_s) begin
                  state_q      <= ERR_PULSE;
                  last_grant_q <= MASTER_DATA;
               end else begin
                  state_q <= GNT_DATA;
               end
            end
            ERR_PULSE: state_q <= IDLE;
            default:   state_q <= IDLE;
         endcase
      end
   end

   // Bus steering. Everything is zero outside a grant, so the async reset of
   // state_q alone forces all outputs low without waiting for a clock.
   always_comb begin
      mem_CYC_O  = 1'b0;
      mem_STB_O  = 1'b0;
      mem_WE_O   = 1'b0;
      mem_SEL_O  = 4'h0;
      mem_ADR_O  = 32'h0000_0000;
      mem_DAT_O  = 32'h0000_0000;
      inst_DAT_O = 32'h0000_0000;
      inst_ACK_O = 1'b0;
      inst_ERR_O = 1'b0;
      data_DAT_O = 32'h0000_0000;
      data_ACK_O = 1'b0;
      data_ERR_O = 1'b0;
      case (state_q)
         GNT_INST: begin
            mem_CYC_O  = inst_CYC_I;
            mem_STB_O  = inst_STB_I;
            mem_SEL_O  = 4'hF;
            mem_ADR_O  = inst_ADR_I;
            inst_ACK_O = mem_ACK_I;
            inst_DAT_O = mem_DAT_I;
            data_DAT_O = mem_DAT_I;
         end
         GNT_DATA: begin
            mem_CYC_O  = data_CYC_I;
            mem_STB_O  = data_STB_I;
            mem_WE_O   = data_WE_I;
            mem_SEL_O  = data_SEL_I;
            mem_ADR_O  = data_ADR_I;
            mem_DAT_O  = data_DAT_I;
            data_ACK_O = mem_ACK_I;
            inst_DAT_O = mem_DAT_I;
            data_DAT_O = mem_DAT_I;
         end
         ERR_PULSE: begin
            inst_ERR_O = (last_grant_q == MASTER_INST);
            data_ERR_O = (last_grant_q == MASTER_DATA);
         end
         IDLE: begin
            mem_CYC_O = 1'b0;
         end
         default: begin
            mem_CYC_O = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Scoreboard bench: instance 0 uses the default watchdog, instance 1 uses an
// 8-cycle watchdog; sel_to routes the masters and slave to one of them.
module tb_wishbone_arbiter;

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] dat;
      int          gap;
   } grant_t;

   typedef struct {
      logic        master;
      logic        err;
      logic [31:0] dat;
      logic        cyc;
      int          lat;
   } resp_t;

   logic        clk, rst_n, sel_to;
   logic        inst_cyc, inst_stb, data_cyc, data_stb, data_we, mem_ack;
   logic [31:0] inst_adr, data_adr, data_wdat, slave_rdata;
   logic [3:0]  data_sel;
   int          ack_delay;

   logic [31:0] inst_dat_o [2];
   logic        inst_ack_o [2];
   logic        inst_err_o [2];
   logic [31:0] data_dat_o [2];
   logic        data_ack_o [2];
   logic        data_err_o [2];
   logic        mem_cyc_o  [2];
   logic        mem_stb_o  [2];
   logic        mem_we_o   [2];
   logic [3:0]  mem_sel_o  [2];
   logic [31:0] mem_adr_o  [2];
   logic [31:0] mem_dat_o  [2];
   logic [138:0] outs_a;

   grant_t exp_grant [$];
   resp_t  exp_resp  [$];
   int n_cmp = 0, n_bad = 0, resp_cnt = 0, cyc_cnt = 0;
   int grant_cyc = 0, gap = 0, s_cnt = 0;
   logic prev_cyc = 1'b0;

   wishbone_arbiter u_dut (
      .CLK_I(clk), .RST_I(rst_n),
      .inst_CYC_I(inst_cyc & ~sel_to), .inst_STB_I(inst_stb), .inst_ADR_I(inst_adr),
      .inst_DAT_O(inst_dat_o[0]), .inst_ACK_O(inst_ack_o[0]), .inst_ERR_O(inst_err_o[0]),
      .data_CYC_I(data_cyc & ~sel_to), .data_STB_I(data_stb), .data_WE_I(data_we),
      .data_SEL_I(data_sel), .data_ADR_I(data_adr), .data_DAT_I(data_wdat),
      .data_DAT_O(data_dat_o[0]), .data_ACK_O(data_ack_o[0]), .data_ERR_O(data_err_o[0]),
      .mem_CYC_O(mem_cyc_o[0]), .mem_STB_O(mem_stb_o[0]), .mem_WE_O(mem_we_o[0]),
      .mem_SEL_O(mem_sel_o[0]), .mem_ADR_O(mem_adr_o[0]), .mem_DAT_O(mem_dat_o[0]),
      .mem_DAT_I(slave_rdata), .mem_ACK_I(mem_ack & ~sel_to)
   );

   wishbone_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_WIDTH(16)) u_dut_to (
      .CLK_I(clk), .RST_I(rst_n),
      .inst_CYC_I(inst_cyc & sel_to), .inst_STB_I(inst_stb), .inst_ADR_I(inst_adr),
      .inst_DAT_O(inst_dat_o[1]), .inst_ACK_O(inst_ack_o[1]), .inst_ERR_O(inst_err_o[1]),
      .data_CYC_I(data_cyc & sel_to), .data_STB_I(data_stb), .data_WE_I(data_we),
      .data_SEL_I(data_sel), .data_ADR_I(data_adr), .data_DAT_I(data_wdat),
      .data_DAT_O(data_dat_o[1]), .data_ACK_O(data_ack_o[1]), .data_ERR_O(data_err_o[1]),
      .mem_CYC_O(mem_cyc_o[1]), .mem_STB_O(mem_stb_o[1]), .mem_WE_O(mem_we_o[1]),
      .mem_SEL_O(mem_sel_o[1]), .mem_ADR_O(mem_adr_o[1]), .mem_DAT_O(mem_dat_o[1]),
      .mem_DAT_I(slave_rdata), .mem_ACK_I(mem_ack & sel_to)
   );

   assign outs_a = {inst_dat_o[0], inst_ack_o[0], inst_err_o[0], data_dat_o[0],
                    data_ack_o[0], data_err_o[0], mem_cyc_o[0], mem_stb_o[0],
                    mem_we_o[0], mem_sel_o[0], mem_adr_o[0], mem_dat_o[0]};

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_resp(input int target);
      int budget = 0;
      while (resp_cnt < target && budget < 300) begin
         step();
         budget++;
      end
      if (resp_cnt < target) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_resp: got %0d responses want %0d", resp_cnt, target);
      end
   endtask

   task automatic push_grant(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                             input logic [31:0] dat, input int g);
      grant_t e;
      e.adr = adr; e.we = we; e.sel = sel; e.dat = dat; e.gap = g;
      exp_grant.push_back(e);
   endtask

   task automatic push_resp(input logic m, input logic err, input logic [31:0] dat,
                            input logic cyc, input int lat);
      resp_t e;
      e.master = m; e.err = err; e.dat = dat; e.cyc = cyc; e.lat = lat;
      exp_resp.push_back(e);
   endtask

   task automatic do_reset();
      step();
      rst_n = 1'b0;
      inst_cyc = 1'b0; inst_stb = 1'b0; data_cyc = 1'b0; data_stb = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   // Slave model: ACK for one cycle once the transaction has been open ack_delay cycles.
   initial begin
      mem_ack = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst_n || !(mem_cyc_o[sel_to] && mem_stb_o[sel_to])) begin
            s_cnt   = 0;
            mem_ack = 1'b0;
         end else begin
            mem_ack = (s_cnt == ack_delay);
            s_cnt   = s_cnt + 1;
         end
      end
   end

   // Monitor: new grants on the rising edge of mem_CYC_O, responses on any ACK/ERR.
   always @(negedge clk) begin
      grant_t g;
      resp_t  r;
      logic   cur, m, e;
      logic [31:0] d;
      if (!rst_n) begin
         prev_cyc = 1'b0;
         gap = 0;
      end else begin
         cur = mem_cyc_o[sel_to];
         if (cur && !prev_cyc) begin
            if (exp_grant.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL grant_unexpected: got adr %h want none", mem_adr_o[sel_to]);
            end else begin
               g = exp_grant.pop_front();
               chk("grant_adr_we_sel_dat",
                   {mem_adr_o[sel_to], mem_we_o[sel_to], mem_sel_o[sel_to], mem_dat_o[sel_to]},
                   {g.adr, g.we, g.sel, g.dat});
               if (g.gap >= 0) chk("grant_idle_gap", gap, g.gap);
            end
            grant_cyc = cyc_cnt;
         end
         gap = cur ? 0 : gap + 1;
         prev_cyc = cur;
         if (inst_ack_o[sel_to] || inst_err_o[sel_to] || data_ack_o[sel_to] || data_err_o[sel_to]) begin
            resp_cnt++;
            m = ~(inst_ack_o[sel_to] | inst_err_o[sel_to]);
            e = inst_err_o[sel_to] | data_err_o[sel_to];
            d = inst_ack_o[sel_to] ? inst_dat_o[sel_to] :
                (data_ack_o[sel_to] ? data_dat_o[sel_to] : 32'h0);
            if (exp_resp.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL resp_unexpected: got master %0d err %0d want none", m, e);
            end else begin
               r = exp_resp.pop_front();
               chk("resp_master_err_dat_cyc",
                   {inst_ack_o[sel_to] & data_ack_o[sel_to], m, e, d, cur},
                   {1'b0, r.master, r.err, r.dat, r.cyc});
               chk("resp_latency", cyc_cnt - grant_cyc, r.lat);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; sel_to = 1'b0; ack_delay = -1; slave_rdata = 32'h5A5A_5A5A;
      inst_cyc = 1'b0; inst_stb = 1'b0; inst_adr = 32'h0;
      data_cyc = 1'b0; data_stb = 1'b0; data_we = 1'b0; data_sel = 4'h0;
      data_adr = 32'h0; data_wdat = 32'h0;
      #1;
      chk("reset_outputs_zero", outs_a, 160'h0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // Fetch only, ACK 10 cycles into the grant.
      ack_delay = 10; slave_rdata = 32'hCAFE_0001;
      push_grant(32'h0000_0010, 1'b0, 4'hF, 32'h0, -1);
      push_resp(1'b0, 1'b0, 32'hCAFE_0001, 1'b1, 10);
      inst_adr = 32'h0000_0010; inst_cyc = 1'b1; inst_stb = 1'b1;
      wait_resp(1);
      inst_cyc = 1'b0; inst_stb = 1'b0;
      repeat (2) step();

      // Data store only.
      ack_delay = 3; slave_rdata = 32'h1234_5678;
      push_grant(32'h0100_0004, 1'b1, 4'h5, 32'hDEAD_BEEF, -1);
      push_resp(1'b1, 1'b0, 32'h1234_5678, 1'b1, 3);
      data_adr = 32'h0100_0004; data_we = 1'b1; data_sel = 4'h5; data_wdat = 32'hDEAD_BEEF;
      data_cyc = 1'b1; data_stb = 1'b1;
      wait_resp(2);
      chk("cyc_low_after_ack", mem_cyc_o[0], 1'b0);
      data_cyc = 1'b0; data_stb = 1'b0; data_we = 1'b0;
      repeat (2) step();

      // Contention: six transactions, strictly alternating, one IDLE between.
      do_reset();
      ack_delay = 2; slave_rdata = 32'hA5A5_0000;
      inst_adr = 32'h0000_0100;
      data_adr = 32'h0000_0200; data_sel = 4'hF; data_wdat = 32'h0;
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) push_grant(32'h0000_0100, 1'b0, 4'hF, 32'h0, (i == 0) ? -1 : 1);
         else            push_grant(32'h0000_0200, 1'b0, 4'hF, 32'h0, 1);
         push_resp(i % 2, 1'b0, 32'hA5A5_0000, 1'b1, 2);
      end
      inst_cyc = 1'b1; inst_stb = 1'b1; data_cyc = 1'b1; data_stb = 1'b1;
      wait_resp(8);
      inst_cyc = 1'b0; inst_stb = 1'b0; data_cyc = 1'b0; data_stb = 1'b0;
      repeat (2) step();

      // Timeout on the 8-cycle instance, then a normal fetch.
      sel_to = 1'b1;
      do_reset();
      ack_delay = -1;
      push_grant(32'hF000_0000, 1'b0, 4'hF, 32'h0, -1);
      push_resp(1'b1, 1'b1, 32'h0, 1'b0, 8);
      data_adr = 32'hF000_0000; data_we = 1'b0; data_sel = 4'hF;
      data_cyc = 1'b1; data_stb = 1'b1;
      wait_resp(9);
      data_cyc = 1'b0; data_stb = 1'b0;
      ack_delay = 4; slave_rdata = 32'h0BAD_F00D;
      push_grant(32'h0000_0020, 1'b0, 4'hF, 32'h0, 2);
      push_resp(1'b0, 1'b0, 32'h0BAD_F00D, 1'b1, 4);
      inst_adr = 32'h0000_0020; inst_cyc = 1'b1; inst_stb = 1'b1;
      wait_resp(10);
      inst_cyc = 1'b0; inst_stb = 1'b0;
      repeat (2) step();

      // ACK on the expiry cycle wins over the timeout.
      ack_delay = 7; slave_rdata = 32'h7777_0007;
      push_grant(32'h0000_0030, 1'b0, 4'hF, 32'h0, -1);
      push_resp(1'b1, 1'b0, 32'h7777_0007, 1'b1, 7);
      data_adr = 32'h0000_0030; data_cyc = 1'b1; data_stb = 1'b1;
      wait_resp(11);
      data_cyc = 1'b0; data_stb = 1'b0;
      repeat (3) step();

      // Fetch abort with a pending data request.
      sel_to = 1'b0;
      do_reset();
      ack_delay = -1; slave_rdata = 32'h0000_ABCD;
      push_grant(32'h0000_0040, 1'b0, 4'hF, 32'h0, -1);
      inst_adr = 32'h0000_0040; inst_cyc = 1'b1; inst_stb = 1'b1;
      step();
      data_adr = 32'h0000_0050; data_we = 1'b1; data_sel = 4'h3; data_wdat = 32'h0000_1111;
      data_cyc = 1'b1; data_stb = 1'b1;
      repeat (3) step();
      inst_cyc = 1'b0; inst_stb = 1'b0;
      #1;
      chk("abort_cyc_same_cycle", mem_cyc_o[0], 1'b0);
      ack_delay = 2;
      push_grant(32'h0000_0050, 1'b1, 4'h3, 32'h0000_1111, 2);
      push_resp(1'b1, 1'b0, 32'h0000_ABCD, 1'b1, 2);
      wait_resp(12);
      data_cyc = 1'b0; data_stb = 1'b0; data_we = 1'b0;
      repeat (2) step();

      // Reset asserted between clock edges in the middle of a grant.
      ack_delay = -1;
      push_grant(32'h0000_0060, 1'b0, 4'hF, 32'h0, -1);
      inst_adr = 32'h0000_0060; inst_cyc = 1'b1; inst_stb = 1'b1;
      repeat (4) step();
      chk("grant_before_reset", mem_cyc_o[0], 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("midgrant_reset_outputs_zero", outs_a, 160'h0);
      inst_cyc = 1'b0; inst_stb = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (3) step();

      chk("grant_queue_drained", exp_grant.size(), 0);
      chk("resp_queue_drained", exp_resp.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wishbone_arbiter.md
Name: wishbone_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter sitting directly upstream of memory_controller.
- Merges the core's instruction-fetch port and data (load/store) port into the single cpu_* slave interface of memory_controller.
- Uses round-robin grant held until ACK, master abort or timeout.
- A per-transaction watchdog returns ERR to the granted master when the addressed slave never acknowledges.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles a granted transaction may wait for slave ACK before ERR; legal range 2..65535.
- TIMEOUT_WIDTH, 16, width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  reset, asynchronous, active-low
- inst_CYC_I  in  1  fetch-master cycle
- inst_STB_I  in  1  fetch-master strobe
- inst_ADR_I  in  32  fetch address
- inst_DAT_O  out  32  fetch read data
- inst_ACK_O  out  1  fetch acknowledge
- inst_ERR_O  out  1  fetch timeout error
- data_CYC_I  in  1  data-master cycle
- data_STB_I  in  1  data-master strobe
- data_WE_I  in  1  data write enable
- data_SEL_I  in  4  byte selects
- data_ADR_I  in  32  data address
- data_DAT_I  in  32  write data
- data_DAT_O  out  32  read data
- data_ACK_O  out  1  data acknowledge
- data_ERR_O  out  1  data timeout error
- mem_CYC_O  out  1  to memory_controller cpu_CYC_I
- mem_STB_O  out  1  to cpu_STB_I
- mem_WE_O  out  1  to cpu_WE_I
- mem_SEL_O  out  4  to cpu_SEL_I
- mem_ADR_O  out  32  to cpu_ADR_I
- mem_DAT_O  out  32  to cpu_DAT_I
- mem_DAT_I  in  32  from cpu_DAT_O
- mem_ACK_I  in  1  from cpu_ACK_O

Behaviour:
- Reset:
  - The state machine enters IDLE.
  - last_grant = DATA, so the first tie goes to INST.
  - Watchdog = 0.
  - All outputs are 0 while RST_I = 0, independent of the clock.
  - Reset mid-transaction drops mem_CYC_O immediately. No ACK or ERR is forwarded.
- States:
  - IDLE, GNT_INST, GNT_DATA, ERR_PULSE.
- Arbitration in IDLE (request = CYC & STB):
  - Only one master requesting: grant it.
  - Both requesting: grant the master that is not last_grant.
  - The transition is registered. Master request at cycle n gives mem_CYC_O/STB_O = 1 from cycle n+1.
- Granted states:
  - mem_* outputs are combinational muxes of the granted master's signals.
  - Instruction grant drives mem_WE_O = 0 and mem_SEL_O = 4'hF. mem_DAT_O is 0 during fetch.
  - mem_ACK_I is forwarded combinationally, only to the granted master's ACK.
  - mem_DAT_I is forwarded to both DAT_O ports; a master qualifies it with its own ACK.
  - The non-granted master's ACK and ERR are 0.
- Completion:
  - mem_ACK_I = 1 in a grant state: next state IDLE and last_grant = the current grantee.
  - mem_CYC_O/STB_O go low in IDLE for at least one cycle. This guarantees memory_controller sees a fresh cycle and prevents a held ACK from double-completing.
- Abort:
  - Granted master deasserts CYC before ACK: mem_CYC_O follows low combinationally and the next state is IDLE.
  - last_grant is updated as on completion.
- Timeout:
  - The watchdog increments each grant cycle without ACK and clears on entering a grant state.
  - When the count reaches TIMEOUT_CYCLES-1 without ACK, the next state is ERR_PULSE.
  - ERR_PULSE: mem_CYC_O = 0, the grantee's ERR_O = 1 for exactly one cycle, then IDLE.
  - ACK arriving in the same cycle as the timeout wins: normal completion, no ERR.
- Simultaneous events:
  - A new request from the other master during a grant waits; it is served first after IDLE if both are then requesting.
  - No starvation: with both continuously requesting, grants strictly alternate.
- Widths:
  - The watchdog saturates; it never wraps.
  - No other arithmetic.

Decomposition:
- Shared package wb_arbiter_pkg holds:
  - The state encoding (IDLE=2'b00, GNT_INST=2'b01, GNT_DATA=2'b10, ERR_PULSE=2'b11).
  - Master index constants (MASTER_INST=0, MASTER_DATA=1).
  - The default TIMEOUT_CYCLES.
- One natural sub-module: wb_watchdog. It is a counter with clear/enable inputs and a registered expired flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Fetch only:
  - Stimulus: fetch of ADR 0x00000010 with slave ACK after 10 cycles.
  - Required: mem_ADR_O = 0x10, mem_SEL_O = 4'hF, mem_WE_O = 0.
  - inst_ACK_O pulses with inst_DAT_O = slave data; data_ACK_O stays 0.
- Data store only:
  - Stimulus: data write of 0xDEADBEEF to 0x01000004, SEL = 4'h5.
  - Required: mem_* mirror these values; data_ACK_O follows mem_ACK_I.
  - mem_CYC_O is 0 the cycle after ACK.
- Contention, both masters requesting continuously for 6 transactions:
  - Grant order is INST, DATA, INST, DATA, INST, DATA.
  - Each grant is separated by one IDLE cycle.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 8, data read to an unmapped address that never ACKs.
  - Required: data_ERR_O = 1 for one cycle, 8 cycles after grant.
  - mem_CYC_O = 0 in that cycle; the next fetch request is then granted normally.
- ACK/timeout collision:
  - Stimulus: ACK on the exact expiry cycle.
  - Required: ACK forwarded, no ERR.
- Abort and reset:
  - Stimulus: inst_CYC_I dropped mid-wait.
  - Required: mem_CYC_O falls the same cycle and a pending data request is granted next.
  - Stimulus: RST_I pulled low mid-grant, between clock edges.
  - Required: all outputs 0 immediately.
